i2c_power_reader: RTL and testbench

I2C_POWER_READER -- requirements
Module: i2c_power_reader

---
 rtl/i2c_power_reader.sv | 242 ++++++++++++++++++++++++
 tb/tb_i2c_power_reader.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_power_reader.sv
// I2C master that repeatedly reads a 16-bit signed register from a power monitor and
// presents it as a 27-bit signed 5.22 sample.
module i2c_power_reader #(
    parameter int unsigned QTR_DIV  = 31,
    parameter logic [6:0]  DEV_ADDR = 7'h40,
    parameter logic [7:0]  REG_PTR  = 8'h01,
    parameter int unsigned GAP_CYC  = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    input  logic        sda_in,
    output logic        scl_oe,
    output logic        sda_oe,
    output logic [26:0] data_out,
    output logic        data_valid,
    output logic        busy,
    output logic        nack_err
);

    localparam int unsigned QW = (QTR_DIV > 0) ? $clog2(QTR_DIV + 1) : 1;
    localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [QW-1:0] QTR_MAX = QW'(QTR_DIV);
    localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYC - 1);
    localparam logic [7:0] ADDR_W = {DEV_ADDR, 1'b0};
    localparam logic [7:0] ADDR_R = {DEV_ADDR, 1'b1};

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_START  = 4'd1;
    localparam logic [3:0] S_WADDR  = 4'd2;
    localparam logic [3:0] S_WACK1  = 4'd3;
    localparam logic [3:0] S_PTR    = 4'd4;
    localparam logic [3:0] S_WACK2  = 4'd5;
    localparam logic [3:0] S_RSTART = 4'd6;
    localparam logic [3:0] S_RADDR  = 4'd7;
    localparam logic [3:0] S_WACK3  = 4'd8;
    localparam logic [3:0] S_RDMSB  = 4'd9;
    localparam logic [3:0] S_MACK   = 4'd10;
    localparam logic [3:0] S_RDLSB  = 4'd11;
    localparam logic [3:0] S_MNACK  = 4'd12;
    localparam logic [3:0] S_STOP   = 4'd13;
    localparam logic [3:0] S_GAP    = 4'd14;

    logic [3:0]    state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    phase_q, phase_d;
    logic [2:0]    bit_q, bit_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic [15:0]   rx_q, rx_d;
    logic          txn_nack_q, txn_nack_d;
    logic          run_q, run_d;
    logic          nack_err_q, nack_err_d;
    logic [26:0]   data_out_q, data_out_d;
    logic          data_valid_q, data_valid_d;
    logic          scl_oe_q, scl_d;
    logic          sda_oe_q, sda_d;

    logic active, qtr_end, sample, bit_end;

    assign active  = (state_q != S_IDLE) && (state_q != S_GAP);
    assign qtr_end = active && (qcnt_q == QTR_MAX);
    assign sample  = qtr_end && (phase_q == 2'd2);
    assign bit_end = qtr_end && (phase_q == 2'd3);

    always_comb begin
        state_d      = state_q;
        qcnt_d       = qcnt_q;
        phase_d      = phase_q;
        bit_d        = bit_q;
        gcnt_d       = gcnt_q;
        rx_d         = rx_q;
        txn_nack_d   = txn_nack_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        run_d        = stop ? 1'b0 : (start ? 1'b1 : run_q);
        nack_err_d   = start ? 1'b0 : nack_err_q;

        if (active) begin
            if (qtr_end) begin
                qcnt_d  = '0;
                phase_d = phase_q + 2'd1;
            end else begin
                qcnt_d = qcnt_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (run_q) begin
                    state_d    = S_START;
                    txn_nack_d = 1'b0;
                end
            end
            S_START:  if (bit_end) begin state_d = S_WADDR; bit_d = 3'd7; end
            S_WADDR, S_PTR, S_RADDR, S_RDMSB, S_RDLSB: begin
                if (sample && (state_q == S_RDMSB || state_q == S_RDLSB)) begin
                    rx_d = {rx_q[14:0], sda_in};
                end
                if (bit_end) begin
                    if (bit_q != 3'd0) begin
                        bit_d = bit_q - 3'd1;
                    end else begin
                        case (state_q)
                            S_WADDR: state_d = S_WACK1;
                            S_PTR:   state_d = S_WACK2;
                            S_RADDR: state_d = S_WACK3;
                            S_RDMSB: state_d = S_MACK;
                            default: state_d = S_MNACK;
                        endcase
                    end
                end
            end
            S_WACK1, S_WACK2, S_WACK3: begin
                if (sample && sda_in) begin
                    txn_nack_d = 1'b1;
                    nack_err_d = 1'b1;
                end
                if (bit_end) begin
                    bit_d = 3'd7;
                    if (txn_nack_q) begin
                        state_d = S_STOP;
                    end else begin
                        case (state_q)
                            S_WACK1: state_d = S_PTR;
                            S_WACK2: state_d = S_RSTART;
                            default: state_d = S_RDMSB;
                        endcase
                    end
                end
            end
            S_RSTART: if (bit_end) begin state_d = S_RADDR; bit_d = 3'd7; end
            S_MACK:   if (bit_end) begin state_d = S_RDLSB; bit_d = 3'd7; end
            S_MNACK:  if (bit_end) state_d = S_STOP;
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_GAP;
                    gcnt_d  = '0;
                    if (!txn_nack_q) begin
                        // raw LSB is 2^-12; 5.22 needs 10 extra fraction bits and one extra sign bit
                        data_out_d   = {rx_q[15], rx_q, 10'b0};
                        data_valid_d = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gcnt_q == GAP_MAX) begin
                    gcnt_d     = '0;
                    state_d    = run_q ? S_START : S_IDLE;
                    txn_nack_d = 1'b0;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus drive is derived from next-state so both open-drain enables come straight from flops.
    always_comb begin
        scl_d = 1'b0;
        sda_d = 1'b0;
        case (state_d)
            S_IDLE, S_GAP: begin
                scl_d = 1'b0;
                sda_d = 1'b0;
            end
            S_START: begin
                scl_d = (phase_d == 2'd3);
                sda_d = (phase_d != 2'd0);
            end
            S_RSTART: begin
                scl_d = (phase_d == 2'd0) || (phase_d == 2'd3);
                sda_d = phase_d[1];
            end
            S_STOP: begin
                scl_d = (phase_d == 2'd0);
                sda_d = !phase_d[1];
            end
            S_WADDR: begin
                scl_d = (phase_d == 2'd0) || (phase_d == 2'd3);
                sda_d = !ADDR_W[bit_d];
            end
            S_PTR: begin
                scl_d = (phase_d == 2'd0) || (phase_d == 2'd3);
                sda_d = !REG_PTR[bit_d];
            end
            S_RADDR: begin
                scl_d = (phase_d == 2'd0) || (phase_d == 2'd3);
                sda_d = !ADDR_R[bit_d];
            end
            S_MACK: begin
                scl_d = (phase_d == 2'd0) || (phase_d == 2'd3);
                sda_d = 1'b1;
            end
            default: begin
                scl_d = (phase_d == 2'd0) || (phase_d == 2'd3);
                sda_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            qcnt_q       <= '0;
            phase_q      <= 2'd0;
            bit_q        <= 3'd7;
            gcnt_q       <= '0;
            rx_q         <= 16'd0;
            txn_nack_q   <= 1'b0;
            run_q        <= 1'b0;
            nack_err_q   <= 1'b0;
            data_out_q   <= 27'd0;
            data_valid_q <= 1'b0;
            scl_oe_q     <= 1'b0;
            sda_oe_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            qcnt_q       <= qcnt_d;
            phase_q      <= phase_d;
            bit_q        <= bit_d;
            gcnt_q       <= gcnt_d;
            rx_q         <= rx_d;
            txn_nack_q   <= txn_nack_d;
            run_q        <= run_d;
            nack_err_q   <= nack_err_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            scl_oe_q     <= scl_d;
            sda_oe_q     <= sda_d;
        end
    end

    assign scl_oe     = scl_oe_q;
    assign sda_oe     = sda_oe_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign busy       = active;
    assign nack_err   = nack_err_q;

endmodule

// File: tb/tb_i2c_power_reader.sv
// Bench for i2c_power_reader: behavioural I2C slave on an open-drain bus, with scoreboard
// queues of expected bus events and expected samples.
module tb_i2c_power_reader;

    localparam int QTR     = 3;
    localparam int GAP     = 50;
    localparam int BIT_CYC = 4 * (QTR + 1);
    localparam int TXN_CYC = 48 * BIT_CYC;

    localparam logic [8:0] EV_START = 9'h100;
    localparam logic [8:0] EV_STOP  = 9'h101;
    localparam logic [8:0] EV_MACK  = 9'h102;
    localparam logic [8:0] EV_MNACK = 9'h103;

    logic        clk = 1'b0;
    logic        reset_n, start, stop;
    logic        scl_oe, sda_oe, data_valid, busy, nack_err;
    logic [26:0] data_out;
    logic        scl_line, sda_line;
    logic        s_drive = 1'b0;

    assign scl_line = ~scl_oe;
    assign sda_line = ~(sda_oe | s_drive);

    i2c_power_reader #(
        .QTR_DIV (QTR),
        .DEV_ADDR(7'h40),
        .REG_PTR (8'h01),
        .GAP_CYC (GAP)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .stop      (stop),
        .sda_in    (sda_line),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .data_out  (data_out),
        .data_valid(data_valid),
        .busy      (busy),
        .nack_err  (nack_err)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [8:0]  ev_q[$];
    logic [26:0] dat_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic log_ev(input logic [8:0] ev);
        if (ev_q.size() == 0) check("bus_ev_unexpected", 32'(ev_q.size()), 32'd1);
        else                  check("bus_ev", {23'd0, ev}, {23'd0, ev_q.pop_front()});
    endtask

    task automatic push_read(input logic [15:0] v);
        ev_q.push_back(EV_START);
        ev_q.push_back(9'h080);
        ev_q.push_back(9'h001);
        ev_q.push_back(EV_START);
        ev_q.push_back(9'h081);
        ev_q.push_back(EV_MACK);
        ev_q.push_back(EV_MNACK);
        ev_q.push_back(EV_STOP);
        dat_q.push_back({v[15], v, 10'b0});
    endtask

    task automatic push_nack();
        ev_q.push_back(EV_START);
        ev_q.push_back(9'h080);
        ev_q.push_back(EV_STOP);
    endtask

    // Slave at 0x40: ACKs address (when present) and pointer, returns s_val MSB first.
    logic        s_present = 1'b1;
    logic [15:0] s_val = 16'h0;
    initial begin
        int         s_st = 0;  // 0 idle, 1 addr, 2 write, 3 read
        int         s_cnt = 0;
        int         s_rbyte = 0;
        logic [7:0] s_byte = 8'h0;
        logic       s_mack = 1'b1;
        logic       ps = 1'b1, pd = 1'b1;
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                s_st = 0; s_cnt = 0; s_drive = 1'b0; ps = 1'b1; pd = 1'b1;
            end else begin
                if (ps && scl_line && pd && !sda_line) begin
                    log_ev(EV_START);
                    s_st = 1; s_cnt = 0; s_drive = 1'b0;
                end else if (ps && scl_line && !pd && sda_line) begin
                    log_ev(EV_STOP);
                    s_st = 0; s_drive = 1'b0;
                end else if (!ps && scl_line && s_st != 0) begin
                    if (s_st != 3 && s_cnt < 8) s_byte = {s_byte[6:0], sda_line};
                    if (s_st == 3 && s_cnt == 8) begin
                        s_mack = sda_line;
                        log_ev(sda_line ? EV_MNACK : EV_MACK);
                    end
                    s_cnt++;
                    if (s_st != 3 && s_cnt == 8) log_ev({1'b0, s_byte});
                end else if (ps && !scl_line && s_st != 0) begin
                    if (s_st != 3) begin
                        if (s_cnt == 8) begin
                            s_drive = (s_st == 2) || (s_present && s_byte[7:1] == 7'h40);
                        end else if (s_cnt == 9) begin
                            s_drive = 1'b0; s_cnt = 0;
                            if (s_st == 1 && s_present && s_byte[7:1] == 7'h40) begin
                                if (s_byte[0]) begin
                                    s_st = 3; s_rbyte = 0; s_drive = ~s_val[15];
                                end else begin
                                    s_st = 2;
                                end
                            end else if (s_st == 1) begin
                                s_st = 0;
                            end
                        end
                    end else begin
                        if (s_cnt == 9) begin
                            s_cnt = 0; s_rbyte++;
                            if (!s_mack && s_rbyte < 2) s_drive = ~s_val[15 - 8 * s_rbyte];
                            else begin s_drive = 1'b0; s_st = 0; end
                        end else if (s_cnt == 8) begin
                            s_drive = 1'b0;
                        end else begin
                            s_drive = ~s_val[15 - 8 * s_rbyte - s_cnt];
                        end
                    end
                end
                ps = scl_line;
                pd = sda_line;
            end
        end
    end

    int cyc = 0;
    int dv_cnt = 0;
    int busy_rise_cnt = 0;
    int t_busy_rise = 0;
    int t_busy_fall = 0;
    int dv_time[$];
    int scl_t[$];
    initial begin
        logic bprev = 1'b0, sprev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (data_valid) begin
                dv_cnt++;
                dv_time.push_back(cyc);
                if (dat_q.size() == 0) check("dv_unexpected", 32'(dat_q.size()), 32'd1);
                else check("data_out", {5'd0, data_out}, {5'd0, dat_q.pop_front()});
            end
            if (busy && !bprev) begin busy_rise_cnt++; t_busy_rise = cyc; end
            if (!busy && bprev) t_busy_fall = cyc;
            if (scl_oe && !sprev) scl_t.push_back(cyc);
            bprev = busy;
            sprev = scl_oe;
        end
    end

    task automatic pulse(input logic st, input logic sp);
        start = st;
        stop  = sp;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input int limit, input string tag);
        int k = 0;
        while (busy !== lvl && k < limit) begin @(negedge clk); k++; end
        check(tag, {31'd0, busy}, {31'd0, lvl});
    endtask

    task automatic wait_dv(input int n, input int limit, input string tag);
        int k = 0;
        while (dv_cnt < n && k < limit) begin @(negedge clk); k++; end
        check(tag, 32'(dv_cnt), 32'(n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, r0, k;
        reset_n = 1'b0; start = 1'b0; stop = 1'b0;
        #1;
        check("rst_scl_oe", {31'd0, scl_oe}, 32'd0);
        check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("rst_data_out", {5'd0, data_out}, 32'd0);
        check("rst_data_valid", {31'd0, data_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_nack_err", {31'd0, nack_err}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_after_reset", {31'd0, busy}, 32'd0);

        // Single read of 0x1234, stop one clk after start
        s_present = 1'b1; s_val = 16'h1234; push_read(16'h1234);
        d0 = dv_cnt;
        pulse(1'b1, 1'b0);
        check("busy_before_idle_exit", {31'd0, busy}, 32'd0);
        pulse(1'b0, 1'b1);
        check("busy_rise", {31'd0, busy}, 32'd1);
        wait_dv(d0 + 1, TXN_CYC + 50, "single_dv_seen");
        repeat (GAP + 20) @(negedge clk);
        check("single_dv_count", 32'(dv_cnt), 32'(d0 + 1));
        check("single_data", {5'd0, data_out}, 32'h0048D000);
        check("single_idle", {31'd0, busy}, 32'd0);
        check("single_nack", {31'd0, nack_err}, 32'd0);
        check("single_ev_done", 32'(ev_q.size()), 32'd0);

        // Negative value
        s_val = 16'hFFF0; push_read(16'hFFF0);
        d0 = dv_cnt;
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        wait_dv(d0 + 1, TXN_CYC + 50, "neg_dv_seen");
        repeat (GAP + 20) @(negedge clk);
        check("neg_dv_count", 32'(dv_cnt), 32'(d0 + 1));
        check("neg_data", {5'd0, data_out}, 32'h07FFC000);

        // No slave: NACK, STOP, retry after the gap
        s_present = 1'b0; push_nack(); push_nack();
        d0 = dv_cnt;
        pulse(1'b1, 1'b0);
        k = 0;
        while (!nack_err && k < 12 * BIT_CYC) begin @(negedge clk); k++; end
        check("nack_set", {31'd0, nack_err}, 32'd1);
        wait_busy(1'b0, 4 * BIT_CYC, "nack_stop_done");
        wait_busy(1'b1, GAP + 10, "nack_retry");
        check("nack_retry_gap", 32'(t_busy_rise - t_busy_fall), 32'(GAP));
        pulse(1'b0, 1'b1);
        wait_busy(1'b0, 14 * BIT_CYC, "nack_retry_done");
        repeat (GAP + 20) @(negedge clk);
        check("nack_no_dv", 32'(dv_cnt), 32'(d0));
        check("nack_sticky", {31'd0, nack_err}, 32'd1);
        check("nack_ev_done", 32'(ev_q.size()), 32'd0);
        s_present = 1'b1; s_val = 16'h7FFF; push_read(16'h7FFF);
        pulse(1'b1, 1'b0);
        check("nack_cleared", {31'd0, nack_err}, 32'd0);
        pulse(1'b0, 1'b1);
        wait_dv(d0 + 1, TXN_CYC + 50, "after_nack_dv");
        repeat (GAP + 20) @(negedge clk);

        // Continuous mode, three transactions; stop arrives mid third transaction
        s_val = 16'h0001;
        for (int i = 0; i < 3; i++) push_read(16'h0001);
        d0 = dv_cnt;
        pulse(1'b1, 1'b0);
        scl_t.delete();
        k = 0;
        while (scl_t.size() < 4 && k < 8 * BIT_CYC) begin @(negedge clk); k++; end
        check("scl_period_a", 32'(scl_t[2] - scl_t[1]), 32'(BIT_CYC));
        check("scl_period_b", 32'(scl_t[3] - scl_t[2]), 32'(BIT_CYC));
        wait_dv(d0 + 2, 2 * (TXN_CYC + GAP) + 50, "cont_dv2");
        wait_busy(1'b1, GAP + 10, "cont_third_start");
        pulse(1'b0, 1'b1);
        wait_dv(d0 + 3, TXN_CYC + 50, "cont_dv3");
        check("cont_spacing_1", 32'(dv_time[dv_time.size() - 2] - dv_time[dv_time.size() - 3]),
              32'(TXN_CYC + GAP));
        check("cont_spacing_2", 32'(dv_time[dv_time.size() - 1] - dv_time[dv_time.size() - 2]),
              32'(TXN_CYC + GAP));
        repeat (GAP + 20) @(negedge clk);
        check("cont_idle", {31'd0, busy}, 32'd0);
        check("cont_dv_count", 32'(dv_cnt), 32'(d0 + 3));

        // Reset while reading the MSB
        s_val = 16'h1234;
        ev_q.push_back(EV_START); ev_q.push_back(9'h080); ev_q.push_back(9'h001);
        ev_q.push_back(EV_START); ev_q.push_back(9'h081);
        d0 = dv_cnt;
        pulse(1'b1, 1'b0);
        k = 0;
        while (ev_q.size() != 0 && k < TXN_CYC) begin @(negedge clk); k++; end
        repeat (40) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_scl_oe", {31'd0, scl_oe}, 32'd0);
        check("midrst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("midrst_data_out", {5'd0, data_out}, 32'd0);
        check("midrst_data_valid", {31'd0, data_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_nack", {31'd0, nack_err}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        r0 = busy_rise_cnt;
        repeat (200) @(negedge clk);
        check("midrst_stays_idle", 32'(busy_rise_cnt), 32'(r0));
        check("midrst_no_dv", 32'(dv_cnt), 32'(d0));

        // start and stop together while idle
        r0 = busy_rise_cnt;
        pulse(1'b1, 1'b1);
        repeat (100) @(negedge clk);
        check("startstop_no_txn", 32'(busy_rise_cnt), 32'(r0));
        check("startstop_busy", {31'd0, busy}, 32'd0);

        check("ev_left", 32'(ev_q.size()), 32'd0);
        check("dat_left", 32'(dat_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
